// File: rtl/wb_stage_pipe_if.sv
// Handshake and payload bundle between the MEM side, the write-back stage and its consumer.
// The stage connects through the slave modport and the driving side through the master modport.
interface wb_stage_pipe_if #(
    parameter int DATA_WITDH = 32,
    parameter int ADDR_WITDH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  reg_wem;
    logic [4:0]            rdm;
    logic [ADDR_WITDH-1:0] pcnm;
    logic [DATA_WITDH-1:0] alu_resultm;
    logic [1:0]            wb_ctrm;
    logic [DATA_WITDH-1:0] data_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  reg_wew;
    logic [4:0]            rdw;
    logic [ADDR_WITDH-1:0] pcnw;
    logic [DATA_WITDH-1:0] alu_resultw;
    logic [1:0]            wb_ctrw;
    logic [DATA_WITDH-1:0] data_outw;
    logic [DATA_WITDH-1:0] wb_data;
    logic                  rf_we;

    modport slave (
        input  flush, in_valid, reg_wem, rdm, pcnm, alu_resultm, wb_ctrm, data_out, out_ready,
        output in_ready, out_valid, reg_wew, rdw, pcnw, alu_resultw, wb_ctrw, data_outw,
               wb_data, rf_we
    );

    modport master (
        output flush, in_valid, reg_wem, rdm, pcnm, alu_resultm, wb_ctrm, data_out, out_ready,
        input  in_ready, out_valid, reg_wew, rdw, pcnw, alu_resultw, wb_ctrw, data_outw,
               wb_data, rf_we
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// Write-back pipeline stage: a 2-entry skid buffer (SKID=1) or a single register (SKID=0)
// holding MEM results, with the write-back value select and register-file write strobe.
module wb_stage_pipe #(
    parameter int DATA_WITDH = 32,
    parameter int ADDR_WITDH = 32,
    parameter int SKID       = 1
) (
    input  logic              clk,
    input  logic              rst,
    wb_stage_pipe_if.slave    bus
);

    typedef struct packed {
        logic                  we;
        logic [4:0]            rd;
        logic [ADDR_WITDH-1:0] pcn;
        logic [DATA_WITDH-1:0] alu;
        logic [1:0]            ctr;
        logic [DATA_WITDH-1:0] dout;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    entry_t main_entry;
    entry_t skid_entry;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   in_ready;
    logic   take_in;
    logic   take_out;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == TWO);

    // The skid variant keeps in_ready purely registered; the single-register variant
    // trades that for full throughput by looking at out_ready.
    assign in_ready = (SKID != 0) ? ~skid_valid : (~main_valid | bus.out_ready);

    assign in_entry = '{we: bus.reg_wem, rd: bus.rdm, pcn: bus.pcnm,
                        alu: bus.alu_resultm, ctr: bus.wb_ctrm, dout: bus.data_out};

    assign take_in  = bus.in_valid & in_ready;
    assign take_out = main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (bus.flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (take_in) begin
                        main_entry <= in_entry;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (take_in && take_out) begin
                        main_entry <= in_entry;
                    end else if (take_in) begin
                        skid_entry <= in_entry;
                        state      <= TWO;
                    end else if (take_out) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (take_out) begin
                        main_entry <= skid_entry;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    logic [DATA_WITDH-1:0] pcn_ext;

    generate
        if (ADDR_WITDH >= DATA_WITDH) begin : g_pcn_trunc
            assign pcn_ext = main_entry.pcn[DATA_WITDH-1:0];
        end else begin : g_pcn_zext
            assign pcn_ext = {{(DATA_WITDH-ADDR_WITDH){1'b0}}, main_entry.pcn};
        end
    endgenerate

    logic [DATA_WITDH-1:0] wb_sel;

    always_comb begin
        wb_sel = '0;
        case (main_entry.ctr)
            2'b00:   wb_sel = main_entry.alu;
            2'b01:   wb_sel = main_entry.dout;
            2'b10:   wb_sel = pcn_ext;
            default: wb_sel = '0;
        endcase
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = main_valid;
    assign bus.reg_wew     = main_entry.we;
    assign bus.rdw         = main_entry.rd;
    assign bus.pcnw        = main_entry.pcn;
    assign bus.alu_resultw = main_entry.alu;
    assign bus.wb_ctrw     = main_entry.ctr;
    assign bus.data_outw   = main_entry.dout;
    assign bus.wb_data     = wb_sel;
    // x0 is hardwired, so writes to it never strobe the register file.
    assign bus.rf_we       = main_valid & main_entry.we & (main_entry.rd != 5'd0) & bus.out_ready;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Table-driven bench for wb_stage_pipe: one SKID=1 and one SKID=0 instance share stimulus,
// a FIFO scoreboard supplies the expected head payload of the instance under test.
module tb_wb_stage_pipe;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] pcn;
        logic [31:0] alu;
        logic [1:0]  ctr;
        logic [31:0] dout;
    } ent_t;

    typedef struct packed {
        logic chk;
        logic zchk;
        logic rst;
        logic flush;
        logic iv;
        logic ordy;
        ent_t e;
        logic exp_ir;
        logic exp_ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic iv = 1'b0;
    logic ordy = 1'b0;
    ent_t drv = '0;
    logic sel = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;
    int row = 0;

    vec_t tab1[$];
    vec_t tab0[$];
    ent_t q[$];

    always #5 clk = ~clk;

    wb_stage_pipe_if #(.DATA_WITDH(32), .ADDR_WITDH(32)) bus1 ();
    wb_stage_pipe_if #(.DATA_WITDH(32), .ADDR_WITDH(32)) bus0 ();

    assign bus1.flush = flush;       assign bus0.flush = flush;
    assign bus1.in_valid = iv;       assign bus0.in_valid = iv;
    assign bus1.out_ready = ordy;    assign bus0.out_ready = ordy;
    assign bus1.reg_wem = drv.we;    assign bus0.reg_wem = drv.we;
    assign bus1.rdm = drv.rd;        assign bus0.rdm = drv.rd;
    assign bus1.pcnm = drv.pcn;      assign bus0.pcnm = drv.pcn;
    assign bus1.alu_resultm = drv.alu; assign bus0.alu_resultm = drv.alu;
    assign bus1.wb_ctrm = drv.ctr;   assign bus0.wb_ctrm = drv.ctr;
    assign bus1.data_out = drv.dout; assign bus0.data_out = drv.dout;

    wb_stage_pipe #(.DATA_WITDH(32), .ADDR_WITDH(32), .SKID(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    wb_stage_pipe #(.DATA_WITDH(32), .ADDR_WITDH(32), .SKID(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    function automatic ent_t mk(logic we, logic [4:0] rd, logic [31:0] pcn, logic [31:0] alu,
                                logic [1:0] ctr, logic [31:0] dout);
        ent_t e;
        e.we = we; e.rd = rd; e.pcn = pcn; e.alu = alu; e.ctr = ctr; e.dout = dout;
        return e;
    endfunction

    function automatic vec_t v(logic chk, logic zchk, logic r, logic f, logic i, logic o,
                               ent_t e, logic ir, logic ov);
        vec_t x;
        x.chk = chk; x.zchk = zchk; x.rst = r; x.flush = f; x.iv = i; x.ordy = o;
        x.e = e; x.exp_ir = ir; x.exp_ov = ov;
        return x;
    endfunction

    function automatic logic [31:0] model_wb(ent_t e);
        case (e.ctr)
            2'b00:   return e.alu;
            2'b01:   return e.dout;
            2'b10:   return e.pcn;
            default: return 32'h0;
        endcase
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (row %0d, skid=%0d): got %h, expected %h", name, row, sel, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t x);
        @(negedge clk);
        rst = x.rst; flush = x.flush; iv = x.iv; ordy = x.ordy; drv = x.e;
    endtask

    task automatic checkOutput(vec_t x);
        logic        a_ov, a_ir, a_we;
        logic [4:0]  a_rd;
        logic [31:0] a_alu, a_pcn, a_wb;
        ent_t        h;
        #1;
        a_ov  = sel ? bus1.out_valid   : bus0.out_valid;
        a_ir  = sel ? bus1.in_ready    : bus0.in_ready;
        a_we  = sel ? bus1.rf_we       : bus0.rf_we;
        a_rd  = sel ? bus1.rdw         : bus0.rdw;
        a_alu = sel ? bus1.alu_resultw : bus0.alu_resultw;
        a_pcn = sel ? bus1.pcnw        : bus0.pcnw;
        a_wb  = sel ? bus1.wb_data     : bus0.wb_data;
        if (x.chk) begin
            cmp("out_valid", {31'b0, a_ov}, {31'b0, x.exp_ov});
            cmp("in_ready", {31'b0, a_ir}, {31'b0, x.exp_ir});
            if (x.exp_ov) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL scoreboard_empty (row %0d): got no expected entry, required one", row);
                end else begin
                    h = q[0];
                    cmp("alu_resultw", a_alu, h.alu);
                    cmp("rdw", {27'b0, a_rd}, {27'b0, h.rd});
                    cmp("pcnw", a_pcn, h.pcn);
                    cmp("wb_data", a_wb, model_wb(h));
                    cmp("rf_we", {31'b0, a_we},
                        {31'b0, h.we & (h.rd != 5'd0) & x.ordy});
                end
            end else begin
                cmp("rf_we_idle", {31'b0, a_we}, 32'h0);
            end
            if (x.zchk) begin
                cmp("rdw_zero", {27'b0, a_rd}, 32'h0);
                cmp("wb_data_zero", a_wb, 32'h0);
            end
        end
    endtask

    task automatic update_model(vec_t x);
        @(posedge clk);
        if (x.rst || x.flush) begin
            q.delete();
        end else begin
            if (x.ordy && q.size() > 0) void'(q.pop_front());
            if (x.iv && x.exp_ir) q.push_back(x.e);
        end
    endtask

    initial begin
        ent_t z;
        z = '0;

        // reset, then post-reset state
        tab1.push_back(v(0, 0, 1, 0, 0, 0, z, 1, 0));
        tab1.push_back(v(0, 0, 1, 0, 0, 0, z, 1, 0));
        tab1.push_back(v(1, 1, 0, 0, 0, 1, z, 1, 0));
        // back-to-back stream
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 0, 32'h11, 0, 0), 1, 0));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 0, 32'h22, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 0, 32'h33, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 0, 32'h44, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 0));
        // backpressure into state TWO, C refused, then drain
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 3, 0, 32'hA0, 0, 0), 1, 0));
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 3, 0, 32'hB0, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 3, 0, 32'hC0, 0, 0), 0, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 3, 0, 32'hC0, 0, 0), 0, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 3, 0, 32'hC0, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 0));
        // write-back select and x0
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 32'h0, 32'h1, 2'b01, 32'hDEAD), 1, 0));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 32'h104, 32'h2, 2'b10, 32'h0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 5, 32'h0, 32'h55, 2'b11, 32'h0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 0, 32'h0, 32'h99, 2'b00, 32'h0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 0));
        // flush in TWO with a same-cycle input, then flush in ONE with an accepted input
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 7, 0, 32'hA1, 0, 0), 1, 0));
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 7, 0, 32'hA2, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 1, 1, 0, mk(1, 7, 0, 32'h77, 0, 0), 0, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 0));
        tab1.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 7, 0, 32'h78, 0, 0), 1, 0));
        tab1.push_back(v(1, 0, 0, 1, 1, 1, mk(1, 7, 0, 32'h79, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 0));
        // reset while stalled in TWO
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 9, 32'h8, 32'hB1, 0, 0), 1, 0));
        tab1.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 9, 32'h8, 32'hB2, 0, 0), 1, 1));
        tab1.push_back(v(1, 0, 1, 0, 0, 0, z, 0, 1));
        tab1.push_back(v(1, 1, 0, 0, 0, 0, z, 1, 0));

        // single-register variant: combinational in_ready from out_ready
        tab0.push_back(v(0, 0, 1, 0, 0, 0, z, 1, 0));
        tab0.push_back(v(1, 1, 0, 0, 0, 0, z, 1, 0));
        tab0.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 4, 0, 32'h10, 0, 0), 1, 0));
        tab0.push_back(v(1, 0, 0, 0, 1, 0, mk(1, 4, 0, 32'h20, 0, 0), 0, 1));
        tab0.push_back(v(1, 0, 0, 0, 1, 1, mk(1, 4, 0, 32'h20, 0, 0), 1, 1));
        tab0.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 1));
        tab0.push_back(v(1, 0, 0, 0, 0, 1, z, 1, 0));

        sel = 1'b1;
        for (int i = 0; i < tab1.size(); i++) begin
            row = i;
            applyStimulus(tab1[i]);
            checkOutput(tab1[i]);
            update_model(tab1[i]);
        end

        sel = 1'b0;
        q.delete();
        for (int i = 0; i < tab0.size(); i++) begin
            row = i;
            applyStimulus(tab0[i]);
            checkOutput(tab0[i]);
            update_model(tab0[i]);
        end

        // Same-cycle check: register full and stalled, then out_ready rises mid-cycle.
        applyStimulus(v(0, 0, 0, 0, 1, 0, mk(1, 4, 0, 32'h30, 0, 0), 1, 0));
        @(negedge clk);
        iv = 1'b0;
        ordy = 1'b0;
        #1;
        cmp("skid0_ready_stalled", {31'b0, bus0.in_ready}, 32'h0);
        ordy = 1'b1;
        #1;
        cmp("skid0_ready_comb", {31'b0, bus0.in_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
